// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: FSM states, queued command record,
// and the data value returned on an aborted cycle.
package wb_master_pkg;
   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = WB_DW / 8;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   typedef struct packed {
      logic             we;
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] dat;
      logic [WB_SW-1:0] sel;
   } wb_cmd_t;

   localparam logic [WB_DW-1:0] RSP_ERR_DATA = '0;
endpackage

// File: rtl/wb_cmd_fifo.sv
// Command FIFO of wb_cmd_t, DEPTH a power of two; pointers wrap naturally.
// A push while full is dropped, so the caller gates push with !full (cmd_ready).
module wb_cmd_fifo
   import wb_master_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    sys_clk,
   input  logic    sys_rst_n,
   input  logic    push,
   input  wb_cmd_t push_cmd,
   input  logic    pop,
   output wb_cmd_t head,
   output logic    full,
   output logic    empty
);
   localparam int PW = $clog2(DEPTH);

   wb_cmd_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

   // storage needs no reset: the count gates every read of it
   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr] <= push_cmd;
   end
endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic master: buffered command stream in, one single-beat cycle per command,
// response stream out. Define WB_MASTER_TIMEOUT_EN to abort cycles that wait TIMEOUT cycles for ack.
module wb_cmd_master
   import wb_master_pkg::*;
#(
   parameter  int AW      = WB_AW,
   parameter  int DW      = WB_DW,
   parameter  int DEPTH   = 4,
   parameter  int TIMEOUT = 255,
   localparam int SW      = DW / 8
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_adr,
   input  logic [DW-1:0] cmd_dat,
   input  logic [SW-1:0] cmd_sel,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_dat,
   output logic          rsp_err,
   output logic [AW-1:0] adr,
   output logic [DW-1:0] dat_w,
   output logic [SW-1:0] sel,
   output logic          we,
   output logic          cyc,
   output logic          stb,
   input  logic [DW-1:0] dat_r,
   input  logic          ack,
   output logic          busy
);
   state_t  state, state_nxt;
   wb_cmd_t cmd_in, fifo_head;
   logic    fifo_full, fifo_empty, fifo_pop, bus_end, bus_tmo;

   assign cmd_in    = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
   assign cmd_ready = !fifo_full;
   assign busy      = !fifo_empty || (state != IDLE);

   wb_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (cmd_valid),
      .push_cmd  (cmd_in),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int TW_RAW = $clog2(TIMEOUT + 1);
   localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);
   logic [TW-1:0] tmo_cnt;

   // counts edges spent in BUS without ack; aborts on the TIMEOUT-th one unless ack lands there too
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)          tmo_cnt <= '0;
      else if (state != BUS)   tmo_cnt <= '0;
      else if (!ack)           tmo_cnt <= tmo_cnt + 1'b1;
   end
   assign bus_tmo = (state == BUS) && !ack && (tmo_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)   rsp_err <= 1'b0;
      else if (bus_end) rsp_err <= !ack;
   end
`else
   logic timeout_unused;
   assign timeout_unused = ^32'(TIMEOUT);
   assign bus_tmo        = 1'b0;
   assign rsp_err        = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      bus_end   = 1'b0;
      unique case (state)
         IDLE: if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = BUS;
         end
         BUS: if (ack || bus_tmo) begin
            bus_end   = 1'b1;
            state_nxt = RESP;
         end
         // RESP always spans a cycle with cyc low, letting the slave drop ack
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         adr       <= '0;
         dat_w     <= '0;
         sel       <= '0;
         we        <= 1'b0;
         cyc       <= 1'b0;
         stb       <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
      end else begin
         if (fifo_pop) begin
            adr   <= fifo_head.adr;
            dat_w <= fifo_head.dat;
            sel   <= fifo_head.sel;
            we    <= fifo_head.we;
            cyc   <= 1'b1;
            stb   <= 1'b1;
         end
         if (bus_end) begin
            cyc       <= 1'b0;
            stb       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= (ack && !we) ? dat_r : RSP_ERR_DATA;
         end
         if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: a queue-based model of accepted commands and expected
// responses plus a behavioural slave with programmable ack latency.
module tb_wb_cmd_master;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic        sys_clk, sys_rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_dat;
   logic [31:0] adr, dat_w, dat_r;
   logic [3:0]  sel;
   logic        we, cyc, stb, ack, busy;

   wb_cmd_master #(.AW(32), .DW(32), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .adr(adr), .dat_w(dat_w), .sel(sel), .we(we), .cyc(cyc), .stb(stb),
      .dat_r(dat_r), .ack(ack), .busy(busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; } tcmd_t;
   typedef struct { logic [31:0] dat; logic err; } trsp_t;

   tcmd_t to_send[$], exp_q[$], cur;
   trsp_t rsp_q[$];
   int    n_vec = 0, n_err = 0;
   int    cyc_n = 0, bus_edges = 0, lat = 1, idle = 1, offer_cyc = 0;
   int    vld_pct = 100, rdy_pct = 100, lat_lo = 1, lat_hi = 4;
   bit    in_bus = 0, rdy_seen = 1, rsvld_seen = 0, probe = 0;
   bit    rdat_fix_en = 0;
   logic [31:0] rdat_fix = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   function automatic tcmd_t rand_cmd();
      tcmd_t c;
      c.we  = 1'($urandom_range(0, 1));
      c.adr = $urandom;
      c.dat = $urandom;
      c.sel = 4'($urandom_range(0, 15));
      return c;
   endfunction

   // one clock: account for what the edge did, check outputs, then drive inputs for the next edge
   task automatic cycle();
      trsp_t r;
      @(posedge sys_clk); #1;
      cyc_n++;
      if (cmd_valid && rdy_seen) exp_q.push_back(to_send.pop_front());
      if (rsvld_seen && rsp_ready && rsp_q.size() != 0) void'(rsp_q.pop_front());
      if (in_bus) begin
         bus_edges++;
         if (ack) begin
            r.dat = cur.we ? 32'h0 : dat_r; r.err = 1'b0;
            rsp_q.push_back(r); in_bus = 0;
         end
`ifdef WB_MASTER_TIMEOUT_EN
         else if (bus_edges == TMO) begin
            r.dat = 32'h0; r.err = 1'b1;
            rsp_q.push_back(r); in_bus = 0;
         end
`endif
         if (!in_bus) chk("rsp_after_ack", rsp_valid, 1);
      end
      if (cyc && !in_bus) begin
         chk("idle_gap", (idle >= 1), 1);
         chk("issue_while_rsp", rsp_q.size(), 0);
         if (exp_q.size() == 0) chk("spurious_cyc", 1, 0);
         else begin
            cur = exp_q.pop_front(); in_bus = 1; bus_edges = 0;
            lat = $urandom_range(lat_lo, lat_hi);
            if (probe) begin chk("issue_latency", cyc_n - offer_cyc, 2); probe = 0; end
         end
      end
      if (in_bus) begin
         chk("bus_ctl", {cyc, stb}, 2'b11);
         chk("bus_adr", adr, cur.adr);
         chk("bus_dat", dat_w, cur.dat);
         chk("bus_sel", sel, cur.sel);
         chk("bus_we", we, cur.we);
      end else chk("bus_idle", {cyc, stb}, 2'b00);
      if (rsp_valid) begin
         if (rsp_q.size() == 0) chk("spurious_rsp", 1, 0);
         else begin
            chk("rsp_dat", rsp_dat, rsp_q[0].dat);
            chk("rsp_err", rsp_err, rsp_q[0].err);
         end
      end else chk("rsp_missing", rsp_q.size(), 0);
      chk("cmd_ready", cmd_ready, (exp_q.size() < DEPTH));
      chk("busy", busy, (exp_q.size() != 0 || in_bus || rsp_q.size() != 0));
      idle = cyc ? 0 : idle + 1;

      rdy_seen   = cmd_ready;
      rsvld_seen = rsp_valid;
      dat_r      = rdat_fix_en ? rdat_fix : $urandom;
      ack        = in_bus ? (bus_edges + 1 == lat) : ($urandom_range(0, 7) == 0);
      rsp_ready  = ($urandom_range(0, 99) < rdy_pct);
      cmd_valid  = (to_send.size() != 0) && ($urandom_range(0, 99) < vld_pct);
      if (cmd_valid) begin
         cmd_we = to_send[0].we; cmd_adr = to_send[0].adr;
         cmd_dat = to_send[0].dat; cmd_sel = to_send[0].sel;
         if (probe && offer_cyc == 0) offer_cyc = cyc_n;
      end else begin
         cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
      end
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((to_send.size() != 0 || exp_q.size() != 0 || rsp_q.size() != 0 || in_bus) && n < max) begin
         cycle(); n++;
      end
      chk("drain_done", (to_send.size() == 0 && exp_q.size() == 0 && rsp_q.size() == 0 && !in_bus), 1);
      cycle();
   endtask

   initial begin
      tcmd_t c;
      sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
      rsp_ready = 1'b1; ack = 1'b0; dat_r = '0;
      #3;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cyc_stb", {cyc, stb}, 2'b00);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_dat}, '0);
      chk("rst_bus", {we, sel, adr, dat_w}, '0);
      chk("rst_busy", busy, 0);
      #9 sys_rst_n = 1'b1;

      // single write, slave acks on the third BUS edge; latency from offer to stb
      lat_lo = 3; lat_hi = 3; probe = 1; offer_cyc = 0;
      c.we = 1; c.adr = 32'h10; c.dat = 32'hDEADBEEF; c.sel = 4'hF;
      to_send.push_back(c);
      drain(50);

      // single read with fixed slave data
      rdat_fix_en = 1; rdat_fix = 32'h1234_0002; lat_lo = 1; lat_hi = 2;
      c.we = 0; c.adr = 32'h20; c.dat = $urandom; c.sel = 4'hF;
      to_send.push_back(c);
      drain(50);
      rdat_fix_en = 0;

      // five back-to-back commands against a stalling slave
      lat_lo = 8; lat_hi = 8;
      for (int i = 0; i < 5; i++) to_send.push_back(rand_cmd());
      drain(200);

      // response held unconsumed; the queued command must stay in the FIFO
      lat_lo = 2; lat_hi = 2; rdy_pct = 0;
      to_send.push_back(rand_cmd());
      begin
         int n = 0;
         while (rsp_q.size() == 0 && n < 30) begin cycle(); n++; end
         chk("t4_rsp_seen", rsp_q.size(), 1);
      end
      to_send.push_back(rand_cmd());
      repeat (10) cycle();
      chk("t4_not_issued", exp_q.size(), 1);
      rdy_pct = 100;
      drain(50);

`ifdef WB_MASTER_TIMEOUT_EN
      // slave never acks, then acks exactly on the limit edge
      lat_lo = 1000; lat_hi = 1000;
      to_send.push_back(rand_cmd());
      drain(100);
      lat_lo = TMO; lat_hi = TMO;
      to_send.push_back(rand_cmd());
      drain(100);
`endif

      // randomized traffic
      lat_lo = 1; lat_hi = 5; vld_pct = 60; rdy_pct = 70;
      for (int i = 0; i < 200; i++) to_send.push_back(rand_cmd());
      drain(5000);

      // reset in the middle of a bus cycle with two commands queued
      vld_pct = 100; rdy_pct = 100; lat_lo = 50; lat_hi = 50;
      for (int i = 0; i < 3; i++) to_send.push_back(rand_cmd());
      begin
         int n = 0;
         while (!(in_bus && exp_q.size() == 2) && n < 50) begin cycle(); n++; end
         chk("rst_setup", (in_bus && exp_q.size() == 2), 1);
      end
      #3 sys_rst_n = 1'b0; cmd_valid = 1'b0; ack = 1'b0;
      #1;
      chk("arst_cyc_stb", {cyc, stb}, 2'b00);
      chk("arst_busy", busy, 0);
      chk("arst_cmd_ready", cmd_ready, 1);
      chk("arst_rsp_valid", rsp_valid, 0);
      to_send.delete(); exp_q.delete(); rsp_q.delete();
      in_bus = 0; idle = 1; rdy_seen = 1; rsvld_seen = 0;
      repeat (2) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      lat_lo = 1; lat_hi = 4;
      repeat (20) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
